wb_sched: RTL
=============

Name: wb_sched

Overview:
- Register-file write-port scheduler for the 3-stage core's writeback stage.
- Merges two write sources onto the single RF write port:
  - in-order writebacks from stage 3, which WControl qualifies;
  - late-returning data-cache load responses.
- Tracks outstanding loads in a small queue, sign/zero-extends load data, resolves port collisions with a skid register, and raises stall and load-use hazard signals to the pipeline.

Parameters:
LDQ_DEPTH, 2, max outstanding loads; power of 2, >=2
XLEN, 32, datapath width

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
wb_valid  in  1  stage-3 writeback request (rwe already applied)
wb_rd  in  5  destination register
wb_data  in  XLEN  non-load result (ALU/PC+4/CSR)
wb_is_load  in  1  request is a load; data arrives via dc_resp
ld_funct3  in  3  load funct3
ld_addr_lo  in  2  load address bits [1:0]
dc_resp_valid  in  1  dcache load data valid (in order, one per cycle max)
dc_resp_data  in  XLEN  raw aligned word
rs1, rs2  in  5  decode-stage sources for hazard check
rf_we  out  1  registered RF write enable
rf_waddr  out  5  registered RF write address
rf_wdata  out  XLEN  registered RF write data
stall  out  1  pipeline must hold wb_* inputs this cycle
rs1_hazard, rs2_hazard  out  1  source matches a pending write
ldq_empty, ldq_full  out  1  load queue status
resp_err  out  1  sticky: response arrived with queue empty

Behaviour:
- Reset (async, any time, including mid-load): clears the load queue and skid register, and drives the following outputs.
  - Zero: rf_we, rf_waddr, rf_wdata, resp_err, stall.
  - One: ldq_empty.
  - In-flight responses are lost.
- stall = skid_valid | ldq_full. It is purely a function of state, with no combinational path from wb_* inputs.
- When stall=1, wb_* inputs are ignored. Requests are accepted only when wb_valid & !stall.
- Accepted load: enqueue {rd, funct3, addr_lo}. rd=0 is still enqueued so the response is consumed, but its write is suppressed.
- Accepted non-load with rd=0: dropped, never written.
- Write-port priority per cycle:
  1. dc response (queue non-empty);
  2. skid entry;
  3. accepted non-load wb.
- An accepted non-load that loses arbitration is captured in the skid register (skid_valid=1).
- The winner appears on rf_we/rf_waddr/rf_wdata one cycle later (registered). rf_we=0 in cycles with no winner. rf_waddr and rf_wdata hold their previous values when rf_we=0.
- Enqueue and dequeue may happen in the same cycle; the count is unchanged. Pointers wrap modulo LDQ_DEPTH.
- dc_resp_valid with the queue empty: ignored, no write, resp_err set until reset.
- Load extension, selected by addr_lo:
  - LB (000) / LBU (100): byte addr_lo.
  - LH (001) / LHU (101): halfword addr_lo[1].
  - LW (010): whole word.
  - Any other funct3: raw word.
- rsN_hazard = (rsN != 0) & (rsN matches rd of any valid queue entry with rd != 0, or the skid entry's rd).
- Pending writes are not forwarded; the hazard signals only.

Optional Feature:
- Macro WB_SCHED_PERF_EN. When defined, adds two outputs:
  - collision_cnt (32): increments each cycle a non-load wb is sent to skid;
  - stall_cnt (32): increments each cycle stall=1.
- Both reset to 0 asynchronously and wrap at 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Non-load wb rd=5 data=0x1234 with no response pending -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x00001234.
- LB rd=3 addr_lo=2, then resp 0x80FF7F00 -> rf_wdata=0xFFFFFFFF (byte 0xFF sign-extended); LBU same -> 0x000000FF; LH addr_lo=2 -> 0xFFFF80FF.
- Load rd=7 pending, then non-load rd=9 data=0xA in the same cycle as the response 0x55 -> cycle+1 writes x7=0x55, cycle+2 writes x9=0xA; stall=1 for exactly one cycle; rs1=9 gives rs1_hazard=1 while skid is held.
- Three loads back-to-back with LDQ_DEPTH=2 -> ldq_full=1 and stall=1 after the 2nd; the 3rd is accepted only after the first response; order of writes is preserved.
- Load rd=0 then resp 0xDEAD -> no rf_we; ldq_empty returns to 1. A response with the queue empty -> resp_err=1, no write.
- Assert reset with 2 loads pending -> ldq_empty=1, stall=0, rf_we=0 immediately, without waiting for a clock edge. With WB_SCHED_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/wb_sched.sv
// Writeback-port scheduler: merges stage-3 writebacks and data-cache load responses onto one RF write port.
// Optional performance counters are enabled by defining WB_SCHED_PERF_EN.
module wb_sched #(
    parameter int LDQ_DEPTH = 2,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_is_load,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic            dc_resp_valid,
    input  logic [XLEN-1:0] dc_resp_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            stall,
    output logic            rs1_hazard,
    output logic            rs2_hazard,
    output logic            ldq_empty,
    output logic            ldq_full,
    output logic            resp_err
`ifdef WB_SCHED_PERF_EN
    ,
    output logic [31:0]     collision_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;

    // Sub-word select and extension of an aligned load word.
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0]      f3,
                                                 input logic [1:0]      lo,
                                                 input logic [XLEN-1:0] raw);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = raw[{lo, 3'b000} +: 8];
        h = lo[1] ? raw[31:16] : raw[15:0];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            3'b010:  r = raw;
            default: r = raw;
        endcase
        return r;
    endfunction

    logic [4:0]           q_rd_q [LDQ_DEPTH];
    logic [4:0]           q_rd_d [LDQ_DEPTH];
    logic [2:0]           q_f3_q [LDQ_DEPTH];
    logic [2:0]           q_f3_d [LDQ_DEPTH];
    logic [1:0]           q_lo_q [LDQ_DEPTH];
    logic [1:0]           q_lo_d [LDQ_DEPTH];
    logic [LDQ_DEPTH-1:0] q_vld_q, q_vld_d;
    logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [4:0]           skid_rd_q, skid_rd_d;
    logic [XLEN-1:0]      skid_data_q, skid_data_d;
    logic                 rf_we_q, rf_we_d;
    logic [4:0]           rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic                 resp_err_q, resp_err_d;

    logic empty_s, full_s, stall_s, accept_s, deq_s, enq_s, wb_write_s, collide_s;
    logic rs1_hit_s, rs2_hit_s;

    assign empty_s    = ~|q_vld_q;
    assign full_s     = &q_vld_q;
    assign stall_s    = skid_valid_q | full_s;
    assign accept_s   = wb_valid & ~stall_s;
    assign enq_s      = accept_s & wb_is_load;
    assign deq_s      = dc_resp_valid & ~empty_s;
    assign wb_write_s = accept_s & ~wb_is_load & (wb_rd != 5'd0);
    // Skid is empty whenever a request is accepted, so only a response can displace it.
    assign collide_s  = wb_write_s & deq_s;

    // Load queue next state: enqueue at tail, retire at head.
    always_comb begin
        q_rd_d  = q_rd_q;
        q_f3_d  = q_f3_q;
        q_lo_d  = q_lo_q;
        q_vld_d = q_vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (deq_s) begin
            q_vld_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end
        if (enq_s) begin
            q_rd_d[tail_q]  = wb_rd;
            q_f3_d[tail_q]  = ld_funct3;
            q_lo_d[tail_q]  = ld_addr_lo;
            q_vld_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
    end

    // Write-port arbitration: response, then skid, then fresh non-load writeback.
    always_comb begin
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        skid_valid_d = skid_valid_q;
        skid_rd_d    = skid_rd_q;
        skid_data_d  = skid_data_q;
        resp_err_d   = resp_err_q | (dc_resp_valid & empty_s);
        if (deq_s) begin
            // A response for rd=0 still owns the port this cycle but writes nothing.
            if (q_rd_q[head_q] != 5'd0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = q_rd_q[head_q];
                rf_wdata_d = load_ext(q_f3_q[head_q], q_lo_q[head_q], dc_resp_data);
            end else begin
                rf_we_d = 1'b0;
            end
        end else if (skid_valid_q) begin
            rf_we_d      = 1'b1;
            rf_waddr_d   = skid_rd_q;
            rf_wdata_d   = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (wb_write_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
        end else begin
            rf_we_d = 1'b0;
        end
        if (collide_s) begin
            skid_valid_d = 1'b1;
            skid_rd_d    = wb_rd;
            skid_data_d  = wb_data;
        end else begin
            skid_rd_d = skid_rd_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LDQ_DEPTH; i++) begin
                q_rd_q[i] <= 5'd0;
                q_f3_q[i] <= 3'd0;
                q_lo_q[i] <= 2'd0;
            end
            q_vld_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_rd_q    <= 5'd0;
            skid_data_q  <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            q_rd_q       <= q_rd_d;
            q_f3_q       <= q_f3_d;
            q_lo_q       <= q_lo_d;
            q_vld_q      <= q_vld_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            skid_valid_q <= skid_valid_d;
            skid_rd_q    <= skid_rd_d;
            skid_data_q  <= skid_data_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Source-operand hazard against queued loads and the skid entry.
    always_comb begin
        rs1_hit_s = skid_valid_q & (skid_rd_q == rs1);
        rs2_hit_s = skid_valid_q & (skid_rd_q == rs2);
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if (q_vld_q[i] && (q_rd_q[i] != 5'd0)) begin
                rs1_hit_s = rs1_hit_s | (q_rd_q[i] == rs1);
                rs2_hit_s = rs2_hit_s | (q_rd_q[i] == rs2);
            end else begin
                rs1_hit_s = rs1_hit_s;
                rs2_hit_s = rs2_hit_s;
            end
        end
    end

    assign rs1_hazard = (rs1 != 5'd0) & rs1_hit_s;
    assign rs2_hazard = (rs2 != 5'd0) & rs2_hit_s;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign stall      = stall_s;
    assign ldq_empty  = empty_s;
    assign ldq_full   = full_s;
    assign resp_err   = resp_err_q;

`ifdef WB_SCHED_PERF_EN
    logic [31:0] collision_cnt_q, collision_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Event counters, wrapping at 2^32.
    always_comb begin
        collision_cnt_d = collision_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        if (collide_s) begin
            collision_cnt_d = collision_cnt_q + 32'd1;
        end else begin
            collision_cnt_d = collision_cnt_q;
        end
        if (stall_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_cnt_q <= 32'd0;
            stall_cnt_q     <= 32'd0;
        end else begin
            collision_cnt_q <= collision_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign collision_cnt = collision_cnt_q;
    assign stall_cnt     = stall_cnt_q;
`endif

endmodule
